// File: rtl/ifetch_unit_pkg.sv
// Shared encodings for the fetch front end: ctrl's PC_sel/IsJump codes,
// opcode field positions, fetch FSM states and the redirect target helpers.
package ifetch_unit_pkg;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_STALL = 2'd1,
    IF_DROP  = 2'd2
  } if_state_e;

  localparam logic [1:0] PC_MUX_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_MUX_SEL_BRANCH = 2'b01;
  localparam logic [1:0] IS_JUMP_NONE      = 2'b00;
  localparam logic [1:0] IS_JUMP_J         = 2'b01;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  // j keeps the 256 MB region of the delay-slot PC
  function automatic logic [31:0] jump_target(input logic [3:0]  pc_plus4_hi,
                                              input logic [25:0] instr_index);
    return {pc_plus4_hi, instr_index, 2'b00};
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [15:0] imm16);
    return pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_fifo.sv
// Two-entry {pc, inst} decode queue; flush wins over push, push and pop
// may coincide even when full.
module ifetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        push,
  input  logic [63:0] push_data,
  input  logic        pop,
  input  logic        flush,
  output logic [63:0] head_data,
  output logic        full,
  output logic        empty
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  logic [63:0] mem_q [2];
  logic [63:0] mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        do_push, do_pop;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == 2'd0);
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC register, word-aligned memory requests,
// decode queue, and the PC redirect driven by ctrl's resolved decisions.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_inst,
  input  logic [1:0]  ex_pc_sel,
  input  logic [1:0]  ex_is_jump,
  input  logic        ex_cond,
  output logic        redirect
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] stale_q, stale_d;
  logic        req_en_q, req_en_d;
  logic        redirect_q, redirect_d;

  logic [31:0] ex_pc_plus4;
  logic [31:0] target;
  logic        take;
  logic        ack, pop, push;
  logic        fifo_full, fifo_empty;
  logic [63:0] head;
  logic        unused_opcode;

  assign ex_pc_plus4   = ex_pc + 32'd4;
  assign unused_opcode = ^ex_inst[OPCODE_MSB:OPCODE_LSB];

  always_comb begin
    take   = 1'b0;
    target = '0;
    if (ex_valid) begin
      if (ex_is_jump == IS_JUMP_J) begin
        take   = 1'b1;
        target = jump_target(ex_pc_plus4[31:28], ex_inst[25:0]);
      end else if ((ex_pc_sel == PC_MUX_SEL_BRANCH) && ex_cond) begin
        take   = 1'b1;
        target = branch_target(ex_pc_plus4, ex_inst[15:0]);
      end
    end
  end

  // req_en_q keeps the bus idle for the cycle in which reset is released
  assign im_req     = req_en_q && (state_q != IF_STALL);
  assign im_addr    = (state_q == IF_DROP) ? stale_q : pc_q;
  assign ack        = im_req && im_ack;
  assign inst_valid = !fifo_empty;
  assign pop        = inst_valid && inst_ready;
  assign inst       = head[31:0];
  assign inst_pc    = head[63:32];
  assign redirect   = redirect_q;
  assign req_en_d   = 1'b1;
  assign redirect_d = take;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stale_d = stale_q;
    push    = 1'b0;
    unique case (state_q)
      IF_FETCH: begin
        if (take) begin
          pc_d    = target;
          stale_d = pc_q;
          state_d = (ack || !req_en_q) ? IF_FETCH : IF_DROP;
        end else if (ack) begin
          push    = 1'b1;
          pc_d    = pc_q + 32'd4;
          // with two slots, a push onto a non-empty queue fills it
          state_d = (!fifo_empty && !pop) ? IF_STALL : IF_FETCH;
        end
      end
      IF_STALL: begin
        if (take) begin
          pc_d    = target;
          state_d = IF_FETCH;
        end else begin
          state_d = (fifo_full && !pop) ? IF_STALL : IF_FETCH;
        end
      end
      IF_DROP: begin
        if (take) begin
          pc_d = target;
        end
        if (ack) begin
          state_d = IF_FETCH;
        end
      end
      default: state_d = IF_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IF_FETCH;
      pc_q       <= RESET_PC;
      stale_q    <= RESET_PC;
      req_en_q   <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      stale_q    <= stale_d;
      req_en_q   <= req_en_d;
      redirect_q <= redirect_d;
    end
  end

  ifetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .push_data({pc_q, im_rdata}),
    .pop      (pop),
    .flush    (take),
    .head_data(head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: memory model with configurable ack
// latency, scoreboard of expected fetch PCs consumed as decode accepts them.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_inst = '0;
  logic [1:0]  ex_pc_sel = 2'b00;
  logic [1:0]  ex_is_jump = 2'b00;
  logic        ex_cond = 1'b0;
  logic        redirect;

  int          checks = 0;
  int          errors = 0;
  int          lat = 0;
  logic        stray_ack = 1'b0;
  logic [31:0] sb_q [$];

  logic        mem_pending = 1'b0;
  logic [31:0] mem_held = '0;
  int          mem_cnt = 0;

  localparam logic [31:0] J_INST   = {6'b000010, 26'h0000C10};
  localparam logic [31:0] BEQ_BACK = {6'b000100, 5'd1, 5'd2, 16'hFFFE};

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk       (clk),
    .rstn      (rstn),
    .im_req    (im_req),
    .im_addr   (im_addr),
    .im_ack    (im_ack),
    .im_rdata  (im_rdata),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .ex_valid  (ex_valid),
    .ex_pc     (ex_pc),
    .ex_inst   (ex_inst),
    .ex_pc_sel (ex_pc_sel),
    .ex_is_jump(ex_is_jump),
    .ex_cond   (ex_cond),
    .redirect  (redirect)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushSeq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(start + 32'(4 * i));
  endtask

  task automatic applyReset();
    rstn = 1'b0;
    ex_valid = 1'b0;
    @(posedge clk);
    #1;
    sb_q.delete();
    checkOutput("rst_im_req", 32'(im_req), 32'd0);
    checkOutput("rst_im_addr", im_addr, 32'h0000_3000);
    checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_inst", inst, 32'd0);
    checkOutput("rst_inst_pc", inst_pc, 32'd0);
    checkOutput("rst_redirect", 32'(redirect), 32'd0);
    @(posedge clk);
    #2;
    rstn = 1'b1;
  endtask

  task automatic waitReq(input string tag);
    int n = 0;
    step();
    while (!im_req && n < 8) begin
      step();
      n++;
    end
    checkOutput(tag, 32'(im_req), 32'd1);
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (!inst_valid && n < 20) begin
      step();
      n++;
    end
    checkOutput(tag, 32'(inst_valid), 32'd1);
  endtask

  // One-cycle resolved control-flow instruction from the execute side
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] ins,
                               input logic [1:0] sel, input logic [1:0] jmp, input logic cond);
    ex_valid   = 1'b1;
    ex_pc      = pc;
    ex_inst    = ins;
    ex_pc_sel  = sel;
    ex_is_jump = jmp;
    ex_cond    = cond;
    step();
    ex_valid   = 1'b0;
    ex_pc_sel  = 2'b00;
    ex_is_jump = 2'b00;
    ex_cond    = 1'b0;
  endtask

  // Instruction memory: ack after lat waiting cycles, address must hold
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        mem_pending = 1'b0;
        mem_cnt     = 0;
        im_ack      = stray_ack;
        im_rdata    = 32'hDEAD_BEEF;
      end else if (im_req) begin
        if (!mem_pending) begin
          mem_pending = 1'b1;
          mem_held    = im_addr;
          mem_cnt     = 0;
        end else begin
          checkOutput("im_addr_stable", im_addr, mem_held);
        end
        if (mem_cnt >= lat) begin
          im_ack      = 1'b1;
          im_rdata    = word_of(im_addr);
          mem_pending = 1'b0;
        end else begin
          im_ack   = stray_ack;
          im_rdata = 32'hDEAD_BEEF;
          mem_cnt++;
        end
      end else begin
        im_ack   = stray_ack;
        im_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  // Decode side: every accepted head must match the scoreboard
  initial begin
    logic [31:0] exp_pc;
    forever begin
      @(negedge clk);
      if (rstn && inst_valid && inst_ready) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_depth", 32'(sb_q.size()), 32'd1);
        end else begin
          exp_pc = sb_q.pop_front();
          checkOutput("inst_pc", inst_pc, exp_pc);
          checkOutput("inst", inst, word_of(exp_pc));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;

    $display("[TB] sequential fetch, zero-wait memory");
    lat = 0;
    inst_ready = 1'b1;
    applyReset();
    pushSeq(32'h3000, 16);
    waitReq("p1_req_rise");
    checkOutput("p1_addr0", im_addr, 32'h3000);
    step();
    checkOutput("p1_addr1", im_addr, 32'h3004);
    checkOutput("p1_valid1", 32'(inst_valid), 32'd1);
    checkOutput("p1_pc1", inst_pc, 32'h3000);
    step();
    checkOutput("p1_addr2", im_addr, 32'h3008);
    checkOutput("p1_pc2", inst_pc, 32'h3004);
    repeat (4) step();

    $display("[TB] decode back-pressure");
    inst_ready = 1'b0;
    applyReset();
    pushSeq(32'h3000, 16);
    waitReq("p2_req_rise");
    repeat (5) step();
    checkOutput("p2_stall_req", 32'(im_req), 32'd0);
    checkOutput("p2_stall_valid", 32'(inst_valid), 32'd1);
    checkOutput("p2_stall_pc", inst_pc, 32'h3000);
    inst_ready = 1'b1;
    step();
    checkOutput("p2_resume_req", 32'(im_req), 32'd1);
    checkOutput("p2_resume_addr", im_addr, 32'h3008);
    repeat (4) step();

    $display("[TB] jump redirect");
    applyStimulus(32'h3010, J_INST, 2'b00, 2'b01, 1'b0);
    sb_q.delete();
    pushSeq(32'h3040, 16);
    checkOutput("j_addr", im_addr, 32'h3040);
    checkOutput("j_redirect", 32'(redirect), 32'd1);
    checkOutput("j_flushed", 32'(inst_valid), 32'd0);
    step();
    checkOutput("j_redirect_pulse", 32'(redirect), 32'd0);
    checkOutput("j_first_valid", 32'(inst_valid), 32'd1);
    checkOutput("j_first_pc", inst_pc, 32'h3040);
    repeat (3) step();

    $display("[TB] beq taken and not taken");
    applyStimulus(32'h3020, BEQ_BACK, 2'b01, 2'b00, 1'b1);
    sb_q.delete();
    pushSeq(32'h301C, 16);
    checkOutput("beq_t_addr", im_addr, 32'h301C);
    checkOutput("beq_t_redirect", 32'(redirect), 32'd1);
    step();
    checkOutput("beq_t_pc", inst_pc, 32'h301C);
    repeat (2) step();
    applyStimulus(32'h3020, BEQ_BACK, 2'b01, 2'b00, 1'b0);
    checkOutput("beq_nt_redirect", 32'(redirect), 32'd0);
    checkOutput("beq_nt_valid", 32'(inst_valid), 32'd1);
    repeat (4) step();

    $display("[TB] jump priority and target boundaries");
    applyStimulus(32'h3020, J_INST, 2'b01, 2'b01, 1'b1);
    sb_q.delete();
    pushSeq(32'h3040, 16);
    checkOutput("prio_addr", im_addr, 32'h3040);
    repeat (2) step();
    applyStimulus(32'hFFFF_FFF0, {6'b000100, 5'd0, 5'd0, 16'h0008}, 2'b01, 2'b00, 1'b1);
    sb_q.delete();
    pushSeq(32'h0000_0014, 16);
    checkOutput("wrap_addr", im_addr, 32'h0000_0014);
    repeat (2) step();
    applyStimulus(32'h8FFF_FFFC, J_INST, 2'b00, 2'b01, 1'b0);
    sb_q.delete();
    pushSeq(32'h9000_3040, 16);
    checkOutput("region_addr", im_addr, 32'h9000_3040);
    repeat (3) step();

    $display("[TB] redirect with slow memory");
    lat = 3;
    applyReset();
    pushSeq(32'h3000, 16);
    waitReq("p5_req_rise");
    step();
    applyStimulus(32'h3000, {6'b000010, 26'h0000400}, 2'b00, 2'b01, 1'b0);
    sb_q.delete();
    pushSeq(32'h1000, 8);
    checkOutput("p5_stale_req", 32'(im_req), 32'd1);
    checkOutput("p5_stale_addr", im_addr, 32'h3000);
    checkOutput("p5_flushed", 32'(inst_valid), 32'd0);
    n = 0;
    while (im_addr == 32'h3000 && n < 12) begin
      step();
      n++;
    end
    checkOutput("p5_target_addr", im_addr, 32'h1000);
    checkOutput("p5_target_req", 32'(im_req), 32'd1);
    waitValid("p5_valid_seen");
    checkOutput("p5_first_pc", inst_pc, 32'h1000);
    step();

    $display("[TB] reset during outstanding request");
    checkOutput("p6_req_outstanding", 32'(im_req), 32'd1);
    rstn = 1'b0;
    stray_ack = 1'b1;
    #1;
    checkOutput("p6_rst_req", 32'(im_req), 32'd0);
    checkOutput("p6_rst_addr", im_addr, 32'h3000);
    checkOutput("p6_rst_valid", 32'(inst_valid), 32'd0);
    checkOutput("p6_rst_inst", inst, 32'd0);
    checkOutput("p6_rst_pc", inst_pc, 32'd0);
    checkOutput("p6_rst_redirect", 32'(redirect), 32'd0);
    sb_q.delete();
    lat = 0;
    @(posedge clk);
    #2;
    rstn = 1'b1;
    step();
    stray_ack = 1'b0;
    pushSeq(32'h3000, 16);
    checkOutput("p6_req", 32'(im_req), 32'd1);
    checkOutput("p6_addr", im_addr, 32'h3000);
    waitValid("p6_valid_seen");
    checkOutput("p6_first_pc", inst_pc, 32'h3000);
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
